uart_rx: RTL

Receive half of UART0: an 8N1 serial receiver with a 2-flop input synchronizer, mid-bit sampling from a baud-rate down-counter, and a show-ahead receive FIFO. It sits between the `uart0_rx` pad and the UART0 peripheral register interface on the core clock. The core pops received bytes and reads sticky overrun and framing error flags.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divider helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Core clocks per bit period, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read and occupancy outputs; shared by the UART rx and tx paths.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Pop only when data is present; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    do_pop  = rd_en && (cnt != '0);
    do_push = wr_en && ((cnt != CW'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Head is forced to zero when empty so the read port has a defined reset value.
  always_comb begin
    rd_data = (cnt == '0) ? '0 : mem[rd_ptr];
    empty   = (cnt == '0);
    full    = (cnt == CW'(DEPTH));
    count   = cnt;
  end

endmodule

// File: rtl/uart_rx.sv
// UART0 receive path: 8N1 deserializer with input synchronizer, mid-bit sampling and receive FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 10_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx,
  input  logic                              rd_en,
  input  logic                              clr_err,
  output logic [7:0]                        rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              overrun,
  output logic                              frame_err,
  output logic                              busy
);

  localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  logic                 rx_m;
  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [BIT_W-1:0]     bit_idx;
  logic [BIT_W-1:0]     bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 push;
  logic                 set_ovr;
  logic                 set_fe;

  // Two-flop synchronizer for the asynchronous pad; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Next-state, baud counter and push/error decisions; each bit is sampled when the counter hits zero.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    push        = 1'b0;
    set_ovr     = 1'b0;
    set_fe      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = CNT_W'(HALF - 1);
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_nxt   = DATA;
            cnt_nxt     = CNT_W'(DIV - 1);
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_nxt   = CNT_W'(DIV - 1);
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
            if (!full || rd_en) push    = 1'b1;
            else                set_ovr = 1'b1;
            state_nxt = IDLE;
          end else begin
            set_fe    = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky error flags; a new error event takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (set_ovr)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (set_fe)       frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  // Receiver activity indicator.
  always_comb begin
    busy = (state != IDLE);
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (shreg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule
